// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU.
//   DATA_W        : datapath width (32)
//   ALU_OP_*      : opcode encodings accepted on req_opcode
//   alu_state_e   : FSM state encoding (IDLE / SHIFT / RESP)
//   op_is_shift() : true for SLL and SRA
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] ALU_OP_ADD = 5'b00000;
    localparam logic [4:0] ALU_OP_SUB = 5'b00001;
    localparam logic [4:0] ALU_OP_AND = 5'b00010;
    localparam logic [4:0] ALU_OP_OR  = 5'b00011;
    localparam logic [4:0] ALU_OP_SLL = 5'b00100;
    localparam logic [4:0] ALU_OP_SRA = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } alu_state_e;

    function automatic logic op_is_shift(input logic [4:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/alu_mc_shift_step.sv
// One combinational shift step: shifts a 32-bit value left-logical or
// right-arithmetic by min(amount, MAX_STEP) and reports the amount applied.
// Ports:
//   value      in  32  value to shift
//   amount     in  5   requested shift amount (clamped to MAX_STEP)
//   shift_left in  1   1 = SLL (zero fill), 0 = SRA (sign fill)
//   shifted    out 32  shifted value
//   applied    out 5   amount actually shifted this step
module alu_mc_shift_step
    import alu_pkg::*;
#(
    parameter int unsigned MAX_STEP = 1
) (
    input  logic [DATA_W-1:0] value,
    input  logic [4:0]        amount,
    input  logic              shift_left,
    output logic [DATA_W-1:0] shifted,
    output logic [4:0]        applied
);

    localparam logic [4:0] MAX_AMT = 5'(MAX_STEP);

    always_comb begin
        applied = (amount > MAX_AMT) ? MAX_AMT : amount;
        if (shift_left) begin
            shifted = value << applied;
        end else begin
            shifted = $unsigned($signed(value) >>> applied);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked multicycle ALU. ADD/SUB/AND/OR complete in one cycle; SLL/SRA
// iterate SHIFT_STEP bits per cycle, or complete at accept when the barrel
// shifter is compiled in with macro ALU_MC_FAST_SHIFT_EN.
// Flags (isNotEqual, isLessThan) come from A-B and are captured at accept.
// Ports:
//   clock, reset_n                  clock and async active-low reset
//   req_valid/req_ready             request handshake
//   req_opcode, req_shamt           operation and shift amount
//   req_a, req_b                    operands
//   rsp_valid/rsp_ready             response handshake, held until consumed
//   rsp_result, rsp_isNotEqual,
//   rsp_isLessThan, rsp_overflow    registered response payload
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_opcode,
    input  logic [4:0]        req_shamt,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_isNotEqual,
    output logic              rsp_isLessThan,
    output logic              rsp_overflow
);

    alu_state_e        state_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] result_reg;
    logic              not_equal_reg;
    logic              less_than_reg;
    logic              overflow_reg;
    logic [4:0]        remaining_reg;
    logic              shift_left_reg;

    // Accept-time datapath
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic [DATA_W-1:0] shift_at_accept;
    logic [DATA_W-1:0] accept_result;
    logic              accept_ovf;
    logic              go_shift;

    assign sum  = req_a + req_b;
    assign diff = req_a - req_b;
    assign add_ovf = (req_a[DATA_W-1] == req_b[DATA_W-1]) && (sum[DATA_W-1] != req_a[DATA_W-1]);
    // SUB overflows when A and ~B share a sign, i.e. A and B differ in sign.
    assign sub_ovf = (req_a[DATA_W-1] != req_b[DATA_W-1]) && (diff[DATA_W-1] != req_a[DATA_W-1]);

`ifdef ALU_MC_FAST_SHIFT_EN
    // Five cascaded steps of 1,2,4,8,16 bits, each enabled by one shamt bit.
    logic [DATA_W-1:0] stage_val [0:5];
    assign stage_val[0] = req_a;

    for (genvar gi = 0; gi < 5; gi++) begin : g_barrel
        logic [4:0] stage_amt;
        logic [4:0] stage_applied;
        assign stage_amt = req_shamt[gi] ? 5'(1 << gi) : 5'd0;
        alu_mc_shift_step #(
            .MAX_STEP(1 << gi)
        ) u_step (
            .value      (stage_val[gi]),
            .amount     (stage_amt),
            .shift_left (req_opcode == ALU_OP_SLL),
            .shifted    (stage_val[gi+1]),
            .applied    (stage_applied)
        );
    end

    assign shift_at_accept = stage_val[5];
    assign go_shift        = 1'b0;
`else
    localparam logic [4:0] SHIFT_AMT = 5'(SHIFT_STEP);

    logic [DATA_W-1:0] step_shifted;
    logic [4:0]        step_applied;

    // The working value lives in result_reg; it is only visible once rsp_valid rises.
    alu_mc_shift_step #(
        .MAX_STEP(SHIFT_STEP)
    ) u_step (
        .value      (result_reg),
        .amount     (remaining_reg),
        .shift_left (shift_left_reg),
        .shifted    (step_shifted),
        .applied    (step_applied)
    );

    assign shift_at_accept = req_a;
    assign go_shift        = op_is_shift(req_opcode) && (req_shamt != 5'd0);
`endif

    always_comb begin
        accept_result = '0;
        accept_ovf    = 1'b0;
        case (req_opcode)
            ALU_OP_ADD: begin
                accept_result = sum;
                accept_ovf    = add_ovf;
            end
            ALU_OP_SUB: begin
                accept_result = diff;
                accept_ovf    = sub_ovf;
            end
            ALU_OP_AND: accept_result = req_a & req_b;
            ALU_OP_OR:  accept_result = req_a | req_b;
            ALU_OP_SLL: accept_result = shift_at_accept;
            ALU_OP_SRA: accept_result = shift_at_accept;
            default:    accept_result = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            req_ready_reg  <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            result_reg     <= '0;
            not_equal_reg  <= 1'b0;
            less_than_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
            remaining_reg  <= '0;
            shift_left_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        result_reg     <= accept_result;
                        overflow_reg   <= accept_ovf;
                        not_equal_reg  <= (diff != '0);
                        // Sign of A-B corrected by overflow gives the true signed compare.
                        less_than_reg  <= diff[DATA_W-1] ^ sub_ovf;
                        shift_left_reg <= (req_opcode == ALU_OP_SLL);
                        req_ready_reg  <= 1'b0;
                        if (go_shift) begin
                            remaining_reg <= req_shamt;
                            state_reg     <= ST_SHIFT;
                        end else begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
`ifdef ALU_MC_FAST_SHIFT_EN
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
`else
                    result_reg    <= step_shifted;
                    remaining_reg <= remaining_reg - step_applied;
                    if (remaining_reg <= SHIFT_AMT) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        req_ready_reg <= 1'b1;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_result     = result_reg;
    assign rsp_isNotEqual = not_equal_reg;
    assign rsp_isLessThan = less_than_reg;
    assign rsp_overflow   = overflow_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: the driver pushes the hand-computed
// expected response when a request is accepted; the monitor pops on the first
// cycle rsp_valid is seen and re-checks the payload every cycle it is held.
// Latency is counted in clock edges including the accept edge.
module tb_alu_multicycle;

    localparam int unsigned TB_STEP = 1;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [4:0]  req_shamt;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_isNotEqual;
    logic        rsp_isLessThan;
    logic        rsp_overflow;

    alu_multicycle #(
        .SHIFT_STEP(TB_STEP)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_shamt      (req_shamt),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_isNotEqual (rsp_isNotEqual),
        .rsp_isLessThan (rsp_isLessThan),
        .rsp_overflow   (rsp_overflow)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ov;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    bit   have_cur = 0;
    bit   cur_ok   = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_acc = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shift latency depends on the build: the barrel shifter finishes at accept.
    function automatic int shift_lat(input int iterative_lat);
`ifdef ALU_MC_FAST_SHIFT_EN
        return 1;
`else
        return iterative_lat;
`endif
    endfunction

    // Monitor: first valid cycle pops and checks latency; every held cycle checks payload.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n || !rsp_valid) begin
                have_cur = 0;
            end else begin
                if (!have_cur) begin
                    have_cur = 1;
                    if (sb_q.size() == 0) begin
                        cur_ok = 0;
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got result %h, required no response", rsp_result);
                    end else begin
                        cur    = sb_q.pop_front();
                        cur_ok = 1;
                        check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                        $display("rsp op=%b result=%h ne=%b lt=%b ov=%b latency=%0d",
                                 cur.op, rsp_result, rsp_isNotEqual, rsp_isLessThan,
                                 rsp_overflow, cyc - cur.acc + 1);
                    end
                end
                if (cur_ok) begin
                    check("result", rsp_result, cur.res);
                    check("isNotEqual", 32'(rsp_isNotEqual), 32'(cur.ne));
                    check("isLessThan", 32'(rsp_isLessThan), 32'(cur.lt));
                    check("overflow", 32'(rsp_overflow), 32'(cur.ov));
                    check("req_ready_busy", 32'(req_ready), 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ne,
                         input logic exp_lt, input logic exp_ov,
                         input int lat, input bit push);
        int waited;
        exp_t e;
        @(negedge clock);
        req_valid  = 1'b1;
        req_opcode = op;
        req_shamt  = sh;
        req_a      = a;
        req_b      = b;
        waited     = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_timeout: got req_ready=0 for 200 cycles, required 1");
            req_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            last_acc  = cyc;
            req_valid = 1'b0;
            if (push) begin
                e.op  = op;
                e.res = exp_res;
                e.ne  = exp_ne;
                e.lt  = exp_lt;
                e.ov  = exp_ov;
                e.lat = lat;
                e.acc = cyc;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((sb_q.size() != 0 || have_cur || !req_ready) && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        int acc1;
        int waited;
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1;
        int waited;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_shamt  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;

        repeat (2) @(negedge clock);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        reset_n = 1'b1;

        // op, shamt, A, B, result, ne, lt, ov, latency
        issue(5'b00000, 5'd0, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 0, 0, 1, 1, 1);
        issue(5'b00001, 5'd0, 32'h8000_0000, 32'h0F00_0000, 32'h7100_0000, 1, 1, 1, 1, 1);
        issue(5'b00001, 5'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0, 0, 0, 1, 1);
        issue(5'b00001, 5'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1, 1, 1);
        issue(5'b00010, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 1, 0, 1, 1);
        issue(5'b00011, 5'd0, 32'h0000_0005, 32'h0000_000A, 32'h0000_000F, 1, 1, 0, 1, 1);
        issue(5'b00000, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0, 1, 1, 1);
        issue(5'b00000, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 1, 1);
        issue(5'b11111, 5'd0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1, 0, 0, 1, 1);
        issue(5'b00100, 5'd31, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 1, 0, 0, shift_lat(32), 1);
        issue(5'b00101, 5'd4, 32'h8000_0000, 32'h0000_0000, 32'hF800_0000, 1, 1, 0, shift_lat(5), 1);
        issue(5'b00101, 5'd3, 32'h7000_0000, 32'h7000_0000, 32'h0E00_0000, 0, 0, 0, shift_lat(4), 1);
        issue(5'b00100, 5'd0, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 0, 0, 0, 1, 1);
        issue(5'b00101, 5'd31, 32'hF000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1, 0, shift_lat(32), 1);
        wait_drain();

        // Throughput: back-to-back non-shift ops accepted two cycles apart.
        issue(5'b00000, 5'd0, 32'd10, 32'd20, 32'd30, 1, 1, 0, 1, 1);
        acc1 = last_acc;
        issue(5'b00000, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0, 1, 1);
        check("throughput_gap", 32'(last_acc - acc1), 32'd2);
        wait_drain();

        // Back-pressure: response held, stray requests ignored, IDLE right after release.
        @(negedge clock);
        rsp_ready = 1'b0;
        issue(5'b00000, 5'd0, 32'd3, 32'd4, 32'd7, 1, 1, 0, 1, 1);
        waited = 0;
        while (!rsp_valid && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clock);
            req_valid  = 1'b1;
            req_opcode = 5'b00001;
            req_a      = 32'hDEAD_BEEF;
            req_b      = 32'h0000_0001;
        end
        @(negedge clock);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        wait_drain();

        // Reset in the middle of a long shift drops it.
        issue(5'b00100, 5'd20, 32'h0000_0001, 32'h0000_0000, 32'h0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_rsp_result", rsp_result, 32'd0);
        check("midreset_req_ready", 32'(req_ready), 32'd1);
        check("midreset_isNotEqual", 32'(rsp_isNotEqual), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        issue(5'b00000, 5'd0, 32'd1, 32'd1, 32'd2, 0, 0, 0, 1, 1);
        wait_drain();

        repeat (10) @(negedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Handshaked, multicycle ALU execution unit. Accepts one operation per request (opcode, two 32-bit operands, shift amount), computes the result plus `isNotEqual`, `isLessThan` and `overflow`, and returns them on a response channel held until consumed. It is the responder side of the ALU operand interface. Logical and arithmetic ops complete in one cycle. Shifts iterate over several cycles unless the fast shifter is compiled in.

## Interface
- `SHIFT_STEP`, default 1: bits shifted per iteration. Legal values are 1, 2, 4, 8, 16.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_opcode`  in  5  operation code.
- `req_shamt`  in  5  shift amount, used only for SLL/SRA.
- `req_a`  in  32  operand A.
- `req_b`  in  32  operand B.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_result`  out  32  result.
- `rsp_isNotEqual`  out  1  A != B.
- `rsp_isLessThan`  out  1  signed A < B.
- `rsp_overflow`  out  1  signed overflow of ADD/SUB.

## Operation
- Opcodes:
  - 00000 ADD
  - 00001 SUB
  - 00010 AND
  - 00011 OR
  - 00100 SLL (logical left shift of A by shamt)
  - 00101 SRA (arithmetic right shift of A by shamt)
  - any other opcode: result 0, overflow 0, one cycle.
- Arithmetic and width rules:
  - All arithmetic is 32-bit two's complement; the carry-out is discarded.
  - `overflow` = operand signs agree (for SUB, compare A with ~B) and the result sign differs. It is 0 for non-ADD/SUB ops.
  - `isNotEqual` and `isLessThan` are derived from A−B for every opcode.
  - `isLessThan` = diff[31] XOR sub_overflow, so it stays correct when the subtraction overflows.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, latch the request.
    - Non-shift op, or shift with shamt=0: go to RESP.
    - Otherwise: go to SHIFT with remaining=shamt.
  - SHIFT: each cycle, shift the working register by min(SHIFT_STEP, remaining) and subtract that amount from remaining. When remaining ≤ SHIFT_STEP at the edge, perform the final step and go to RESP.
    - SRA fills with A[31]; SLL fills with 0.
  - RESP: `rsp_valid`=1. All `rsp_*` outputs are held stable. On `rsp_ready`, go to IDLE.
- Handshake rules:
  - `req_ready` is 1 only in IDLE. Requests presented in any other state are ignored, with no side effects.
  - `rsp_valid` may not drop without `rsp_ready`.
  - A new request can be accepted only on the cycle after the response is consumed.
- Flags are computed at accept from the latched operands and are unaffected by the shift iterations.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=1, `rsp_valid`=0.
  - `rsp_result`=0, all flags 0, remaining=0.
- Reset asserted in any state aborts the operation immediately and drops the in-flight request or response.
- Non-shift latency: accept on edge k, then `rsp_valid` is 1 after edge k+1.
- Shift latency, shamt s>0, iterative: `rsp_valid` is 1 after edge k+1+ceil(s/SHIFT_STEP).
  - Example: SHIFT_STEP=1, s=31 gives 32 edges.
- Minimum throughput: one op per 2 cycles, with `rsp_ready` tied high and non-shift ops.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.

## Configuration
- Macro: `ALU_MC_FAST_SHIFT_EN`.
  - Defined: a 5-stage barrel shifter executes SLL/SRA at accept, so shift latency equals non-shift latency. SHIFT is unreachable and `SHIFT_STEP` is ignored.
  - Undefined: the iterative shifter is used, as described above.
- Interface and flag behaviour are identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `ALU_OP_ADD`/`SUB`/`AND`/`OR`/`SLL`/`SRA`,
  - the FSM state encoding (IDLE/SHIFT/RESP),
  - the data width constant 32.
- One sub-module: `alu_mc_shift_step`. It is combinational: it shifts a 32-bit value left-logical or right-arithmetic by 0..SHIFT_STEP. It is instantiated once in the iterative build and reused per stage in the fast build.

## Test plan
- ADD 0x40000000 + 0x40000000, `rsp_ready`=1 → `rsp_result`=0x80000000, overflow=1, `rsp_valid` 1 cycle after accept.
- SUB 0x80000000 − 0x0F000000 → result 0x71000000, overflow=1, isLessThan=1, isNotEqual=1. SUB 0x80000000 − 0x80000000 → result 0, overflow=0, isNotEqual=0, isLessThan=0.
- SLL A=0x00000001 shamt=31, SHIFT_STEP=1, iterative build → result 0x80000000 after exactly 32 edges. SRA A=0x80000000 shamt=4 → 0xF8000000 after 5 edges.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → outputs stable and `req_ready`=0. Any new `req_valid` in that window is ignored. Release → IDLE next cycle.
- Reset mid-shift: SLL shamt=20, deassert `reset_n` at cycle 5 → `rsp_valid`=0, `rsp_result`=0, `req_ready`=1. After release, ADD 1+1 → 2.
- Fast build: SRA 0xF0000000 shamt=31 → 0xFFFFFFFF, 1 cycle after accept.
